// File: rtl/l1_l2_arbiter_if.sv
// Bundles the I$/D$ miss ports and the L2 processor-side port shared by l1_l2_arbiter.
// slave: arbiter side (consumes L1 requests, drives L2); master: the surrounding L1s/L2.
interface l1_l2_arbiter_if #(
    parameter int s_line = 256,
    parameter int s_addr = 32
);
    logic              i_read;
    logic [s_addr-1:0] i_address;
    logic [s_line-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [s_addr-1:0] d_address;
    logic [s_line-1:0] d_wdata;
    logic [s_line-1:0] d_rdata;
    logic              d_resp;

    logic              l2_read;
    logic              l2_write;
    logic [s_addr-1:0] l2_address;
    logic [s_line-1:0] l2_wdata;
    logic [s_line-1:0] l2_rdata;
    logic              l2_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output l2_read, l2_write, l2_address, l2_wdata,
        input  l2_rdata, l2_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  l2_read, l2_write, l2_address, l2_wdata,
        output l2_rdata, l2_resp
    );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Shares one L2 line port between I$ and D$: grant 1 cycle after request, resp/rdata pass through same cycle.
// Losing requester simply holds until served; L1_L2_ARBITER_RR_EN selects round-robin instead of fixed D-over-I.
module l1_l2_arbiter (
    input logic           clk,
    input logic           rst,
    l1_l2_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   i_req;
    logic   d_req;
    logic   pick_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef L1_L2_ARBITER_RR_EN
    // last_d = 0 means I was granted last; reset value makes the first tie go to D.
    logic last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state != IDLE && bus.l2_resp) begin
            last_d <= (state == GRANT_D);
        end
    end

    assign pick_d = d_req && (!i_req || !last_d);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // L2 request outputs depend only on state and requester inputs, never on l2_resp.
    always_comb begin
        state_nxt      = state;
        bus.i_rdata    = '0;
        bus.i_resp     = 1'b0;
        bus.d_rdata    = '0;
        bus.d_resp     = 1'b0;
        bus.l2_read    = 1'b0;
        bus.l2_write   = 1'b0;
        bus.l2_address = '0;
        bus.l2_wdata   = '0;

        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = GRANT_D;
                end else if (i_req) begin
                    state_nxt = GRANT_I;
                end
            end

            GRANT_I: begin
                bus.l2_read    = bus.i_read;
                bus.l2_address = bus.i_address;
                if (bus.l2_resp) begin
                    bus.i_resp  = 1'b1;
                    bus.i_rdata = bus.l2_rdata;
                    state_nxt   = IDLE;
                end
            end

            GRANT_D: begin
                // A write takes precedence if both D strobes are raised together.
                bus.l2_write   = bus.d_write;
                bus.l2_read    = bus.d_read & ~bus.d_write;
                bus.l2_address = bus.d_address;
                bus.l2_wdata   = bus.d_wdata;
                if (bus.l2_resp) begin
                    bus.d_resp  = 1'b1;
                    bus.d_rdata = bus.l2_rdata;
                    state_nxt   = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter with an L2 responder model and a queue-based scoreboard monitor.
module tb_l1_l2_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    l1_l2_arbiter_if bus ();

    l1_l2_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } req_t;

    typedef struct {
        logic         is_d;
        logic [255:0] rdata;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   l2_lat = 5;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] line_for(input logic [31:0] a);
        if (a == 32'h0000_1000) return {32{8'hA5}};
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic exp_txn(input logic is_d, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [255:0] wd);
        req_q.push_back('{rd: rd, wr: wr, addr: a, wdata: wd});
        rsp_q.push_back('{is_d: is_d, rdata: line_for(a)});
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_l2_read"},    bus.l2_read,    1'b0);
        check({tag, "_l2_write"},   bus.l2_write,   1'b0);
        check({tag, "_l2_address"}, bus.l2_address, '0);
        check({tag, "_l2_wdata"},   bus.l2_wdata,   '0);
        check({tag, "_i_resp"},     bus.i_resp,     1'b0);
        check({tag, "_d_resp"},     bus.d_resp,     1'b0);
        check({tag, "_i_rdata"},    bus.i_rdata,    '0);
        check({tag, "_d_rdata"},    bus.d_rdata,    '0);
    endtask

    task automatic i_txn(input logic [31:0] a, input bit chk_lat);
        int n;
        n = 0;
        bus.i_read    = 1'b1;
        bus.i_address = a;
        if (chk_lat) begin
            @(negedge clk);
            check("lat_before_grant", bus.l2_read, 1'b0);
        end
        while (!bus.i_resp && n < 100) begin
            @(negedge clk);
            n++;
            if (chk_lat && n == 1) check("lat_grant", bus.l2_read, 1'b1);
        end
        if (!bus.i_resp) begin
            n_cmp++;
            n_err++;
            $display("FAIL i_timeout: got no i_resp expected resp within 100 cycles");
        end
        @(posedge clk);
        #1;
        bus.i_read    = 1'b0;
        bus.i_address = '0;
    endtask

    task automatic d_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [255:0] wd);
        int n;
        n = 0;
        bus.d_read    = rd;
        bus.d_write   = wr;
        bus.d_address = a;
        bus.d_wdata   = wd;
        while (!bus.d_resp && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.d_resp) begin
            n_cmp++;
            n_err++;
            $display("FAIL d_timeout: got no d_resp expected resp within 100 cycles");
        end
        @(posedge clk);
        #1;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // L2 model: answers each request l2_lat cycles after it appears, one-cycle resp pulse.
    initial begin
        int cnt;
        cnt = 0;
        bus.l2_resp  = 1'b0;
        bus.l2_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || bus.l2_resp) begin
                bus.l2_resp  = 1'b0;
                bus.l2_rdata = '0;
                cnt = 0;
            end else if (bus.l2_read || bus.l2_write) begin
                cnt++;
                if (cnt >= l2_lat) begin
                    bus.l2_resp  = 1'b1;
                    bus.l2_rdata = line_for(bus.l2_address);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compares each new L2 request and each L1 completion with the queued expectation.
    initial begin
        logic prev;
        req_t r;
        rsp_t s;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((bus.l2_read || bus.l2_write) && !prev) begin
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_l2_req: got addr %h expected no request", bus.l2_address);
                end else begin
                    r = req_q.pop_front();
                    check("l2_read",    bus.l2_read,    r.rd);
                    check("l2_write",   bus.l2_write,   r.wr);
                    check("l2_address", bus.l2_address, r.addr);
                    check("l2_wdata",   bus.l2_wdata,   r.wdata);
                end
            end
            prev = bus.l2_read || bus.l2_write;
            if (bus.i_resp || bus.d_resp) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none",
                             bus.i_resp, bus.d_resp);
                end else begin
                    s = rsp_q.pop_front();
                    check("i_resp", bus.i_resp, !s.is_d);
                    check("d_resp", bus.d_resp, s.is_d);
                    check("resp_rdata", s.is_d ? bus.d_rdata : bus.i_rdata, s.rdata);
                    check("other_rdata", s.is_d ? bus.i_rdata : bus.d_rdata, '0);
                end
            end
        end
    end

    initial begin
        logic [255:0] wd;
        rst           = 1'b1;
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        // Single I read with grant-latency check.
        exp_txn(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0);
        i_txn(32'h0000_1000, 1'b1);
        idle();

        // Simultaneous I/D reads, three rounds: D then I each round.
        for (int k = 0; k < 3; k++) begin
            exp_txn(1'b1, 1'b1, 1'b0, 32'h0000_0200, '0);
            exp_txn(1'b0, 1'b1, 1'b0, 32'h0000_0100, '0);
            fork
                d_txn(1'b1, 1'b0, 32'h0000_0200, '0);
                i_txn(32'h0000_0100, 1'b0);
            join
            idle();
        end

        // Single D write-back.
        wd = {8{32'h1234_5678}};
        exp_txn(1'b1, 1'b0, 1'b1, 32'h0000_2020, wd);
        d_txn(1'b0, 1'b1, 32'h0000_2020, wd);
        idle();

        // Tie right after a D grant: round-robin favours I, fixed priority favours D.
`ifdef L1_L2_ARBITER_RR_EN
        exp_txn(1'b0, 1'b1, 1'b0, 32'h0000_0600, '0);
        exp_txn(1'b1, 1'b1, 1'b0, 32'h0000_0700, '0);
`else
        exp_txn(1'b1, 1'b1, 1'b0, 32'h0000_0700, '0);
        exp_txn(1'b0, 1'b1, 1'b0, 32'h0000_0600, '0);
`endif
        fork
            d_txn(1'b1, 1'b0, 32'h0000_0700, '0);
            i_txn(32'h0000_0600, 1'b0);
        join
        idle();

        // d_read and d_write together: write wins.
        l2_lat = 3;
        wd = {4{64'hDEAD_BEEF_0BAD_F00D}};
        exp_txn(1'b1, 1'b0, 1'b1, 32'h0000_0300, wd);
        d_txn(1'b1, 1'b1, 32'h0000_0300, wd);
        idle();

        // Reset while GRANT_I waits on L2: request seen, no completion.
        l2_lat = 20;
        req_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0400, wdata: '0});
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0400;
        repeat (3) @(negedge clk);
        check("rst_pre_grant", bus.l2_read, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(posedge clk);
        #1;
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        l2_lat = 5;
        idle();

        exp_txn(1'b0, 1'b1, 1'b0, 32'h0000_0500, '0);
        i_txn(32'h0000_0500, 1'b0);
        idle();
        repeat (3) @(posedge clk);

        check("req_q_drained", req_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Shares the single line-granular L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Sits between both L1 miss ports and the L2 cache's processor-side interface. It selects one requester, forwards that requester's transaction unchanged, and routes the L2 response back to it.
- Transactions are whole 256-bit lines with 32-bit line-aligned addresses.

Parameters:
- s_line, 256, line width in bits for all data buses
- s_addr, 32, address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request
- i_address  in  s_addr  I-cache request address
- i_rdata  out  s_line  line returned to I-cache
- i_resp  out  1  I-cache transaction complete
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write(back) request
- d_address  in  s_addr  D-cache request address
- d_wdata  in  s_line  D-cache write line
- d_rdata  out  s_line  line returned to D-cache
- d_resp  out  1  D-cache transaction complete
- l2_read  out  1  read request to L2
- l2_write  out  1  write request to L2
- l2_address  out  s_addr  address to L2
- l2_wdata  out  s_line  write line to L2
- l2_rdata  in  s_line  line from L2
- l2_resp  in  1  L2 transaction complete

Behaviour:
- Reset: async on rst=1. FSM goes to IDLE and last_grant goes to I. All outputs are 0 while in IDLE.
- Requester contract: a requester holds its request, address and data stable until its resp pulse, then deasserts for at least the cycle after resp. d_read and d_write are never asserted together; if they are, d_write wins and d_read is ignored.
- FSM states:
  - IDLE: no L2 request is driven.
  - GRANT_I: i_read is forwarded to L2.
  - GRANT_D: D-cache signals are forwarded to L2.
- IDLE transitions: if there is no request, stay in IDLE. If only one requester asserts, move to its GRANT state at the next edge. If both assert, arbitrate (see priority).
- GRANT_x:
  - L2 outputs are combinational copies of the granted requester's signals. For GRANT_I, l2_write=0 and l2_wdata=0.
  - While l2_resp=0, stay.
  - When l2_resp=1, in the same cycle x_resp=1 and x_rdata=l2_rdata. Next state is IDLE and last_grant<=x.
- Non-granted requester: resp=0 and rdata=0 at all times.
- Latency: a request seen in IDLE reaches L2 one cycle later. Completion adds 0 cycles (resp is passed through combinationally). There is one mandatory IDLE cycle between back-to-back grants.
- Priority (baseline): fixed, D-cache wins over I-cache.
- Requester drop mid-grant: if the requester deasserts before l2_resp (a protocol violation), the arbiter stays in GRANT until l2_resp and does not re-issue.
- Reset mid-transaction: the grant is abandoned and no resp is emitted. The L2 shares rst and abandons its transaction too.
- No combinational path exists from l2_resp to l2_read/l2_write.

Optional Feature:
- Macro: L1_L2_ARBITER_RR_EN.
- Defined: round-robin priority. On simultaneous requests in IDLE, grant goes to the requester not equal to last_grant. After reset the first tie goes to D, because last_grant resets to I.
- Undefined: fixed D-over-I priority; last_grant register may be optimized away.

Test Plan:
- Single I read, addr 0x0000_1000, L2 responds after 5 cycles with line 0xA5..A5 -> l2_read=1 one cycle after i_read; i_resp=1 and i_rdata=0xA5..A5 for exactly one cycle; d_resp stays 0.
- Single D write, addr 0x0000_2020, wdata 0x1234..: l2_write=1, l2_address=0x0000_2020, l2_wdata matches, l2_read=0 -> d_resp pulses once on l2_resp.
- Simultaneous i_read (0x100) and d_read (0x200), baseline -> D served first; after d_resp and one IDLE cycle, I served (l2_address=0x100); total two L2 transactions.
- Same stimulus with L1_L2_ARBITER_RR_EN, repeated 3 times back-to-back -> grant order D,I,D,I,D,I.
- Assert rst while GRANT_I waits on l2_resp -> all outputs 0 immediately (async); no i_resp; after release, a new i_read is served normally.
- d_read=d_write=1 at 0x300 -> l2_write=1, l2_read=0.
